// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light reaction game.
//   state_t    : round sequencer states
//   LEDS_ALL   : all ten red lights on
//   LEDS_FALSE : alternating pattern shown after a jump start
//   RT_W       : width of the reaction-time counter (fits 0..9999)
//   HOLD_W     : width of the ms counter shared by the light and hold phases
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LIGHTS,
    HOLD,
    GO,
    RESULT,
    FALSE
  } state_t;

  localparam logic [9:0] LEDS_ALL   = 10'h3FF;
  localparam logic [9:0] LEDS_FALSE = 10'b1010101010;
  localparam int         RT_W       = 14;
  localparam int         HOLD_W     = 12;

endpackage

// File: rtl/f1_reaction_ctrl_edge_det.sv
// Registered rising-edge detector, reusable for any KEY-style level input.
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset
//   i_in   : level input
//   o_rise : one-cycle pulse, registered, the cycle after i_in rises
// The history bit resets to 1 so a level already high when reset is
// released is not reported as an edge.
module edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_rise
);

  logic r_q;
  logic r_rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q    <= 1'b1;
      r_rise <= 1'b0;
    end else begin
      r_q    <= i_in;
      r_rise <= i_in & ~r_q;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/f1_reaction_ctrl.sv
// Round controller for the F1 start-light game: runs the ten lights, holds
// for a random interval, releases them and times the driver's reaction.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_tick_ms       : one-cycle pulse per millisecond
//   i_trigger       : button level, active-high
//   i_rnd           : LFSR value, latched at round start
//   o_en_lfsr       : LFSR advance enable (only while idle)
//   o_ledr          : light bank
//   o_rt_ms         : reaction time in ms, saturates at RT_MAX
//   o_rt_valid      : o_rt_ms holds a finished measurement
//   o_timeout       : no press before RT_MAX
//   o_false_start   : press before lights out
//   o_busy          : round in progress (LIGHTS, HOLD, GO)
//
// state  | meaning
// IDLE   | waiting for a press, LFSR running
// LIGHTS | lighting one more lamp every LIGHT_MS ms
// HOLD   | all lamps on for (rnd+1)*DELAY_UNIT_MS ms
// GO     | lamps out, counting reaction ms
// RESULT | showing measurement until next press
// FALSE  | jump start shown until next press
module f1_reaction_ctrl
  import f1_pkg::*;
#(
  parameter int LIGHT_MS      = 500,
  parameter int DELAY_UNIT_MS = 32,
  parameter int RT_MAX        = 9999
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tick_ms,
  input  logic            i_trigger,
  input  logic [5:0]      i_rnd,
  output logic            o_en_lfsr,
  output logic [9:0]      o_ledr,
  output logic [RT_W-1:0] o_rt_ms,
  output logic            o_rt_valid,
  output logic            o_timeout,
  output logic            o_false_start,
  output logic            o_busy
);

  state_t             r_state, w_state_nx;
  logic [9:0]         r_ledr, w_ledr_nx;
  logic [RT_W-1:0]    r_rt_ms, w_rt_ms_nx;
  logic               r_rt_valid, w_rt_valid_nx;
  logic               r_timeout, w_timeout_nx;
  logic               r_false, w_false_nx;
  logic [HOLD_W-1:0]  r_ms_cnt, w_ms_cnt_nx;
  logic [3:0]         r_step, w_step_nx;
  logic [6:0]         r_units, w_units_nx;
  logic               r_en_lfsr;
  logic               r_busy;
  logic               w_press;
  logic [HOLD_W-1:0]  w_ms_inc;
  logic [HOLD_W-1:0]  w_hold_ms;

  edge_det u_press (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_in   (i_trigger),
    .o_rise (w_press)
  );

  assign w_ms_inc  = r_ms_cnt + HOLD_W'(1);
  // 64 units * 32 ms = 2048 still fits the 12-bit counter.
  assign w_hold_ms = HOLD_W'(32'(r_units) * DELAY_UNIT_MS);

  // A press is always checked before any tick so that a jump start on the
  // same cycle as a light step or hold expiry is never forgiven, and a
  // press in GO freezes rt_ms without the coincident increment.
  always_comb begin
    w_state_nx    = r_state;
    w_ledr_nx     = r_ledr;
    w_rt_ms_nx    = r_rt_ms;
    w_rt_valid_nx = r_rt_valid;
    w_timeout_nx  = r_timeout;
    w_false_nx    = r_false;
    w_ms_cnt_nx   = r_ms_cnt;
    w_step_nx     = r_step;
    w_units_nx    = r_units;

    case (r_state)
      IDLE: begin
        w_ledr_nx     = '0;
        w_rt_valid_nx = 1'b0;
        w_timeout_nx  = 1'b0;
        w_false_nx    = 1'b0;
        if (w_press) begin
          w_units_nx  = {1'b0, i_rnd} + 7'd1;
          w_ms_cnt_nx = '0;
          w_step_nx   = '0;
          w_rt_ms_nx  = '0;
          w_state_nx  = LIGHTS;
        end
      end
      LIGHTS: begin
        if (w_press) begin
          w_state_nx = FALSE;
          w_false_nx = 1'b1;
          w_ledr_nx  = LEDS_FALSE;
          w_rt_ms_nx = '0;
        end else if (i_tick_ms) begin
          if (r_ms_cnt == HOLD_W'(LIGHT_MS - 1)) begin
            w_ms_cnt_nx = '0;
            w_ledr_nx   = {r_ledr[8:0], 1'b1};
            w_step_nx   = r_step + 4'd1;
            if (r_step == 4'd9) begin
              w_state_nx = HOLD;
            end
          end else begin
            w_ms_cnt_nx = w_ms_inc;
          end
        end
      end
      HOLD: begin
        w_ledr_nx = LEDS_ALL;
        if (w_press) begin
          w_state_nx = FALSE;
          w_false_nx = 1'b1;
          w_ledr_nx  = LEDS_FALSE;
          w_rt_ms_nx = '0;
        end else if (i_tick_ms) begin
          if (w_ms_inc == w_hold_ms) begin
            w_state_nx  = GO;
            w_ledr_nx   = '0;
            w_rt_ms_nx  = '0;
            w_ms_cnt_nx = '0;
          end else begin
            w_ms_cnt_nx = w_ms_inc;
          end
        end
      end
      GO: begin
        w_ledr_nx = '0;
        if (w_press) begin
          w_state_nx    = RESULT;
          w_rt_valid_nx = 1'b1;
        end else if (i_tick_ms) begin
          if (r_rt_ms >= RT_W'(RT_MAX - 1)) begin
            w_rt_ms_nx    = RT_W'(RT_MAX);
            w_state_nx    = RESULT;
            w_rt_valid_nx = 1'b1;
            w_timeout_nx  = 1'b1;
          end else begin
            w_rt_ms_nx = r_rt_ms + RT_W'(1);
          end
        end
      end
      RESULT: begin
        if (w_press) begin
          w_state_nx    = IDLE;
          w_rt_valid_nx = 1'b0;
          w_timeout_nx  = 1'b0;
        end
      end
      FALSE: begin
        w_ledr_nx = LEDS_FALSE;
        if (w_press) begin
          w_state_nx = IDLE;
          w_false_nx = 1'b0;
          w_ledr_nx  = '0;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_ledr     <= '0;
      r_rt_ms    <= '0;
      r_rt_valid <= 1'b0;
      r_timeout  <= 1'b0;
      r_false    <= 1'b0;
      r_ms_cnt   <= '0;
      r_step     <= '0;
      r_units    <= 7'd1;
      r_en_lfsr  <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_ledr     <= w_ledr_nx;
      r_rt_ms    <= w_rt_ms_nx;
      r_rt_valid <= w_rt_valid_nx;
      r_timeout  <= w_timeout_nx;
      r_false    <= w_false_nx;
      r_ms_cnt   <= w_ms_cnt_nx;
      r_step     <= w_step_nx;
      r_units    <= w_units_nx;
      r_en_lfsr  <= (w_state_nx == IDLE);
      r_busy     <= (w_state_nx == LIGHTS) || (w_state_nx == HOLD) || (w_state_nx == GO);
    end
  end

  assign o_en_lfsr     = r_en_lfsr;
  assign o_ledr        = r_ledr;
  assign o_rt_ms       = r_rt_ms;
  assign o_rt_valid    = r_rt_valid;
  assign o_timeout     = r_timeout;
  assign o_false_start = r_false;
  assign o_busy        = r_busy;

endmodule

// File: doc/f1_reaction_ctrl.md
# f1_reaction_ctrl

Top-level sequencer for the Formula 1 start-light game. It runs the ten red lights, holds them for a pseudo-random interval, and releases them. It then measures the driver's reaction time in milliseconds and flags jump starts. It sits between the ms tick generator, the LFSR, the LED bank and the binary-to-BCD display path, and replaces the separate light FSM and delay blocks with one controller that owns the whole round.

## Interface
Parameters:
- LIGHT_MS, 500: tick_ms pulses between successive light steps.
- DELAY_UNIT_MS, 32: ms per LFSR unit of hold delay.
- RT_MAX, 9999: saturation value of the reaction counter (fits the 4-digit display).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, synchronous, active-high; one clock domain, no other reset.
- tick_ms  in  1  one-cycle enable pulse, once per ms.
- trigger  in  1  button level, active-high (already inverted from KEY).
- rnd  in  6  LFSR output.
- en_lfsr  out  1  LFSR advance enable.
- ledr  out  10  light bank.
- rt_ms  out  14  reaction time, binary ms.
- rt_valid  out  1  rt_ms holds a finished measurement.
- timeout  out  1  no press before RT_MAX.
- false_start  out  1  press occurred before lights out.
- busy  out  1  round in progress (LIGHTS, HOLD or GO).

## Operation
- Press = rising edge of trigger: trigger_q is registered, and a press is trigger & ~trigger_q. trigger_q resets to 1, so a button held through reset is not a press.
- States:
  - IDLE: en_lfsr=1, ledr=0, and all flags are 0 except that rt_ms keeps its last value. On a press:
    - latch delay_units = rnd + 1 (1..64);
    - clear the ms counter and step counter;
    - clear rt_ms, rt_valid, timeout and false_start;
    - go to LIGHTS.
  - LIGHTS: en_lfsr=0. After each LIGHT_MS tick_ms pulses, ledr <= {ledr[8:0],1'b1}. When the 10th step sets ledr=10'h3FF, go to HOLD with the ms counter cleared.
  - HOLD: ledr=10'h3FF. Count tick_ms until the count reaches delay_units*DELAY_UNIT_MS (32..2048 ms), then set ledr=0, clear rt_ms and go to GO.
  - GO: ledr=0. Each tick_ms increments rt_ms.
    - A press goes to RESULT with rt_valid=1.
    - If rt_ms reaches RT_MAX, go to RESULT with rt_valid=1 and timeout=1.
  - RESULT: hold rt_ms and the flags. A press returns to IDLE with flags cleared; rt_ms is retained for display.
  - FALSE: entered on a press in LIGHTS or HOLD. Set false_start=1, ledr=10'b1010101010, rt_ms=0. A press returns to IDLE.
- busy=1 exactly in LIGHTS, HOLD and GO.
- Arithmetic widths:
  - Hold compare uses a 12-bit counter.
  - rt_ms is 14 bits and never exceeds RT_MAX.

## Timing
- Reset values: state IDLE, ledr=0, rt_ms=0, all flags 0, en_lfsr=1, busy=0, trigger_q=1.
- All outputs are registered. A state change is visible the cycle after the causing press or tick.
- Press-to-state latency: 2 cycles from the trigger rising edge (edge register, then state register).
- Simultaneous press and tick_ms in GO: the press wins and rt_ms is not incremented that cycle.
- Press on the cycle of the final light step or the final hold tick: the press wins and the FSM goes to FALSE. A jump start is never forgiven by a coincident transition.
- rt_ms resolution is 1 ms, measured from the first tick_ms after entering GO.
- rst asserted in any state: IDLE with reset values on the next edge; no partial round survives.
- tick_ms is ignored in IDLE, RESULT and FALSE.

## Structure
- Package f1_pkg holds:
  - state_t enum: IDLE, LIGHTS, HOLD, GO, RESULT, FALSE;
  - constants LEDS_ALL=10'h3FF and LEDS_FALSE=10'b1010101010;
  - RT_W=14.
- Sub-module edge_det (clk, rst, in, rise) for the press detector. It is reusable for KEY inputs elsewhere.
- Counters and the FSM live in f1_reaction_ctrl. The display path consumes rt_ms unchanged.

## Test plan
Sim parameters: LIGHT_MS=2, DELAY_UNIT_MS=4, with tick_ms every 5 clk.
- Normal round: with rnd=6'd3, press in IDLE.
  - ledr steps 0x001, 0x003 … 0x3FF at 2-ms spacing.
  - Hold lasts 16 ms, then ledr=0.
  - Press after 123 ticks gives rt_ms=123, rt_valid=1, timeout=0.
- Jump start: press while ledr=0x01F gives false_start=1, ledr=0x2AA, busy=0. The next press returns to IDLE with false_start=0.
- Timeout: no press in GO gives rt_ms stopping at 9999, timeout=1, rt_valid=1. Further ticks leave rt_ms at 9999.
- Coincidence: press in the same cycle as the final hold tick leads to FALSE. Press coincident with tick_ms at rt_ms=50 gives rt_ms=50.
- Reset mid-GO: assert rst for 1 cycle at rt_ms=40 gives IDLE, ledr=0, rt_ms=0, en_lfsr=1. A button held through reset produces no round.
